ahbl_traffic_master: RTL and testbench



---
 rtl/ahbl_traffic_master.sv | 228 ++++++++++++++++++++++
 tb/tb_ahbl_traffic_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_traffic_master.sv
// AHB-Lite master: writes seed+i to base+4*i, reads the words back and counts miscompares/error responses.
// Optional first-error capture ports are enabled by defining AHBL_TRAFFIC_ERR_LOG_EN.
module ahbl_traffic_master #(
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned ERR_WIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [CNT_WIDTH-1:0] num_words,
  input  logic [31:0]          seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [31:0]          HADDR,
  output logic                 HWRITE,
  output logic [1:0]           HTRANS,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic                 HMASTLOCK,
  output logic [31:0]          HWDATA,
  input  logic                 HREADY,
  input  logic                 HRESP,
  input  logic [31:0]          HRDATA
`ifdef AHBL_TRAFFIC_ERR_LOG_EN
  ,
  output logic [31:0]          first_err_addr,
  output logic [31:0]          first_err_data
`endif
);

  localparam int unsigned EW1       = ERR_WIDTH + 1;
  localparam logic [1:0]  TR_IDLE   = 2'b00;
  localparam logic [1:0]  TR_NONSEQ = 2'b10;
  localparam logic [1:0]  TR_SEQ    = 2'b11;
  localparam logic [2:0]  BURST_INC = 3'b001;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WR_LAST, S_READ, S_RD_LAST, S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] idx, idx_nxt;
  logic [CNT_WIDTH-1:0] num_lat, num_nxt;
  logic [31:0]          base_lat, base_nxt;
  logic [31:0]          seed_lat, seed_nxt;
  logic [31:0]          haddr_nxt, hwdata_nxt, haddr_inc;
  logic [1:0]           htrans_nxt;
  logic                 hwrite_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [ERR_WIDTH-1:0] err_nxt;
  logic [EW1-1:0]       err_sum;
  logic [1:0]           err_inc;
  logic                 dph_active, dph_read, beat, resp_hit, mis_hit, last_word;
  logic [31:0]          dph_word, exp_data;

  assign HSIZE     = 3'b010;
  assign HMASTLOCK = 1'b0;

  // idx counts accepted address phases, so the word in the data phase is always idx-1
  assign dph_word  = 32'(idx) - 32'd1;
  assign exp_data  = seed_lat + dph_word;
  assign haddr_inc = HADDR + 32'd4;
  assign last_word = (idx == num_lat - CNT_WIDTH'(1));

  always_comb begin
    dph_active = 1'b0;
    dph_read   = 1'b0;
    unique case (state)
      S_WRITE:   dph_active = (idx != '0);
      S_WR_LAST: dph_active = 1'b1;
      S_READ: begin
        dph_active = (idx != '0);
        dph_read   = (idx != '0);
      end
      S_RD_LAST: begin
        dph_active = 1'b1;
        dph_read   = 1'b1;
      end
      default: ;
    endcase
  end

  assign beat     = dph_active && HREADY;
  assign resp_hit = beat && HRESP;
  assign mis_hit  = beat && dph_read && (HRDATA != exp_data);
  assign err_inc  = 2'(mis_hit) + 2'(resp_hit);
  assign err_sum  = {1'b0, err_count} + EW1'(err_inc);

`ifdef AHBL_TRAFFIC_ERR_LOG_EN
  logic [31:0] fe_addr_nxt, fe_data_nxt;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    num_nxt    = num_lat;
    base_nxt   = base_lat;
    seed_nxt   = seed_lat;
    haddr_nxt  = HADDR;
    htrans_nxt = HTRANS;
    hwrite_nxt = HWRITE;
    hwdata_nxt = HWDATA;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    pass_nxt   = pass;
    err_nxt    = err_sum[ERR_WIDTH] ? '1 : err_sum[ERR_WIDTH-1:0];
`ifdef AHBL_TRAFFIC_ERR_LOG_EN
    fe_addr_nxt = first_err_addr;
    fe_data_nxt = first_err_data;
    if ((mis_hit || resp_hit) && err_count == '0) begin
      fe_addr_nxt = (base_lat & WORD_MASK) + (dph_word << 2);
      fe_data_nxt = HRDATA;
    end
`endif

    unique case (state)
      S_IDLE: begin
        if (start) begin
          err_nxt = '0;
`ifdef AHBL_TRAFFIC_ERR_LOG_EN
          fe_addr_nxt = '0;
          fe_data_nxt = '0;
`endif
          if (num_words == '0) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            pass_nxt  = 1'b1;
          end else begin
            state_nxt  = S_WRITE;
            num_nxt    = num_words;
            base_nxt   = base_addr;
            seed_nxt   = seed;
            idx_nxt    = '0;
            haddr_nxt  = base_addr & WORD_MASK;
            htrans_nxt = TR_NONSEQ;
            hwrite_nxt = 1'b1;
            busy_nxt   = 1'b1;
            pass_nxt   = 1'b0;
          end
        end
      end

      S_WRITE, S_READ: begin
        if (HREADY) begin
          idx_nxt = idx + CNT_WIDTH'(1);
          if (state == S_WRITE) hwdata_nxt = seed_lat + 32'(idx);
          if (last_word) begin
            state_nxt  = (state == S_WRITE) ? S_WR_LAST : S_RD_LAST;
            htrans_nxt = TR_IDLE;
          end else begin
            haddr_nxt  = haddr_inc;
            htrans_nxt = (haddr_inc[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
          end
        end
      end

      S_WR_LAST: begin
        if (HREADY) begin
          state_nxt  = S_READ;
          idx_nxt    = '0;
          haddr_nxt  = base_lat & WORD_MASK;
          htrans_nxt = TR_NONSEQ;
          hwrite_nxt = 1'b0;
        end
      end

      S_RD_LAST: begin
        if (HREADY) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          pass_nxt  = (err_nxt == '0);
        end
      end

      S_DONE: state_nxt = S_IDLE;

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      idx       <= '0;
      num_lat   <= '0;
      base_lat  <= '0;
      seed_lat  <= '0;
      HADDR     <= '0;
      HTRANS    <= TR_IDLE;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      HBURST    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
`ifdef AHBL_TRAFFIC_ERR_LOG_EN
      first_err_addr <= '0;
      first_err_data <= '0;
`endif
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      num_lat   <= num_nxt;
      base_lat  <= base_nxt;
      seed_lat  <= seed_nxt;
      HADDR     <= haddr_nxt;
      HTRANS    <= htrans_nxt;
      HWRITE    <= hwrite_nxt;
      HWDATA    <= hwdata_nxt;
      HBURST    <= (htrans_nxt != TR_IDLE) ? BURST_INC : 3'b000;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_nxt;
`ifdef AHBL_TRAFFIC_ERR_LOG_EN
      first_err_addr <= fe_addr_nxt;
      first_err_data <= fe_data_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ahbl_traffic_master.sv
// Scoreboard bench for ahbl_traffic_master: a memory slave with configurable waits/faults and
// a negedge monitor comparing bus phases and run results against queues filled by the driver.
module tb_ahbl_traffic_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start;
  logic [31:0] base_addr, seed;
  logic [7:0]  num_words;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
`ifdef AHBL_TRAFFIC_ERR_LOG_EN
  logic [31:0] first_err_addr, first_err_data;
`endif

  ahbl_traffic_master dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
`ifdef AHBL_TRAFFIC_ERR_LOG_EN
    , .first_err_addr(first_err_addr), .first_err_data(first_err_data)
`endif
  );

  always #5 HCLK = ~HCLK;

  longint cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave memory model ----------------
  logic [31:0] mem [0:1023];
  logic        dp_valid = 1'b0, dp_write = 1'b0;
  logic [31:0] dp_addr = '0;
  int          wait_left = 0;
  int          cfg_waits = 0;
  bit          cfg_rand = 0, corrupt_en = 0, resp_en = 0;
  logic [31:0] corrupt_addr = '0, resp_addr = '0;

  assign HREADY = !(dp_valid && wait_left != 0);
  assign HRESP  = dp_valid && resp_en && (dp_addr == resp_addr);
  assign HRDATA = (dp_valid && !dp_write) ?
                  (mem[dp_addr[11:2]] ^ {31'd0, corrupt_en && (dp_addr == corrupt_addr)}) : 32'd0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid  <= 1'b0;
      wait_left <= 0;
    end else if (dp_valid && !HREADY) begin
      wait_left <= wait_left - 1;
    end else begin
      if (dp_valid && dp_write) mem[dp_addr[11:2]] <= HWDATA;
      if (HTRANS[1]) begin
        dp_valid  <= 1'b1;
        dp_addr   <= HADDR;
        dp_write  <= HWRITE;
        wait_left <= cfg_rand ? int'($urandom_range(0, 2)) : cfg_waits;
      end else begin
        dp_valid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  tr;
  } aph_t;

  typedef struct {
    longint      cyc;
    logic        pass;
    logic [15:0] err;
    logic [31:0] fe_addr;
    logic [31:0] fe_data;
  } res_t;

  aph_t        addr_q[$];
  logic [31:0] wd_q[$];
  res_t        res_q[$];

  bit          prev_stall = 0;
  logic [66:0] prev_vals = '0;

  always @(negedge HCLK) begin
    if (HRESET) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("stall_hold", {HADDR, HTRANS, HWRITE, HWDATA}, prev_vals);
      if (HREADY && HTRANS != 2'b00) begin
        chk("aphase_pending", 128'(addr_q.size() > 0), 128'd1);
        if (addr_q.size() > 0) begin
          aph_t p;
          p = addr_q.pop_front();
          chk("aphase", {HADDR, HWRITE, HTRANS, HSIZE, HBURST, HMASTLOCK, busy},
              {p.addr, p.wr, p.tr, 3'b010, 3'b001, 1'b0, 1'b1});
        end
      end
      if (dp_valid && dp_write && HREADY) begin
        chk("wdata_pending", 128'(wd_q.size() > 0), 128'd1);
        if (wd_q.size() > 0) chk("wdata", HWDATA, wd_q.pop_front());
      end
      if (done) begin
        chk("done_pending", 128'(res_q.size() > 0), 128'd1);
        if (res_q.size() > 0) begin
          res_t r;
          r = res_q.pop_front();
          chk("done_pass", pass, r.pass);
          chk("done_err", err_count, r.err);
          chk("done_busy", busy, 1'b0);
          if (r.cyc >= 0) chk("done_cycle", 128'(cyc), 128'(r.cyc));
`ifdef AHBL_TRAFFIC_ERR_LOG_EN
          if (r.err != 0) chk("first_err", {first_err_addr, first_err_data}, {r.fe_addr, r.fe_data});
`endif
        end
      end
      prev_stall = !HREADY;
      prev_vals  = {HADDR, HTRANS, HWRITE, HWDATA};
    end
  end

  // ---------------- driver ----------------
  task automatic chk_reset(input string name);
    chk(name, {HTRANS, HADDR, HWRITE, HWDATA, HSIZE, HBURST, HMASTLOCK, busy, done, pass, err_count},
        {2'b00, 32'd0, 1'b0, 32'd0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
  endtask

  // Queue the expected traffic for one run and launch it; kc/kr pick the corrupted / error word (-1: none)
  task automatic launch(input logic [31:0] base, input int n, input logic [31:0] sd,
                        input int w, input bit rw, input int kc, input int kr);
    logic [31:0] b, a;
    aph_t        p;
    res_t        r;
    int          errs;
    b = base & 32'hFFFF_FFFC;
    @(negedge HCLK);
    cfg_waits    = w;
    cfg_rand     = rw;
    corrupt_en   = (kc >= 0 && kc < n);
    corrupt_addr = b + 32'(kc) * 32'd4;
    resp_en      = (kr >= 0 && kr < n);
    resp_addr    = b + 32'(kr) * 32'd4;
    for (int ps = 0; ps < 2; ps++) begin
      for (int i = 0; i < n; i++) begin
        a      = b + 32'(i) * 32'd4;
        p.addr = a;
        p.wr   = (ps == 0);
        p.tr   = (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
        addr_q.push_back(p);
        if (ps == 0) wd_q.push_back(sd + 32'(i));
      end
    end
    errs      = int'(corrupt_en) + 2 * int'(resp_en);
    r.pass    = (errs == 0);
    r.err     = 16'(errs);
    r.cyc     = rw ? -1 : cyc + ((n == 0) ? 1 : 2 * n + 3 + 2 * n * w);
    r.fe_addr = resp_en ? resp_addr : corrupt_addr;
    r.fe_data = resp_en ? 32'd0 : ((sd + 32'(kc)) ^ 32'd1);
    res_q.push_back(r);
    start     = 1'b1;
    base_addr = base;
    num_words = 8'(n);
    seed      = sd;
    @(negedge HCLK);
    start     = 1'b0;
    num_words = 8'($urandom);
    base_addr = $urandom;
    if (n >= 3) begin
      // a start while busy must be ignored
      @(negedge HCLK);
      start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20000 && res_q.size() != 0; k++) @(negedge HCLK);
    chk("done_timeout", 128'(res_q.size()), 128'd0);
    res_q.delete();
    addr_q.delete();
    wd_q.delete();
    @(negedge HCLK);
  endtask

  task automatic run(input logic [31:0] base, input int n, input logic [31:0] sd,
                     input int w, input bit rw, input int kc, input int kr);
    launch(base, n, sd, w, rw, kc, kr);
    wait_done();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; seed = '0;
    repeat (3) @(negedge HCLK);
    chk_reset("reset_values");
    HRESET = 1'b0;
    @(negedge HCLK);

    run(32'h0000_0010, 4, 32'hA5A5_0000, 0, 0, -1, -1);
    run(32'h0000_0010, 4, 32'hA5A5_0000, 2, 0, -1, -1);
    run(32'h0000_03F8, 4, 32'h1234_5678, 0, 0, -1, -1);
    run(32'h0000_0100, 8, 32'hDEAD_0000, 0, 0, 2, -1);
    run(32'h0000_0200, 0, 32'h0, 0, 0, -1, -1);
    run(32'hFFFF_FFFA, 4, 32'hFFFF_FFFE, 1, 0, -1, -1);
    run(32'h0000_0040, 6, 32'h0BAD_F00D, 0, 0, -1, 3);
    run(32'h0000_0080, 5, 32'h5555_AAAA, 1, 0, 4, 4);

    // reset during the read pass, then a clean rerun
    launch(32'h0000_0300, 6, 32'hCAFE_0000, 0, 0, -1, -1);
    for (int k = 0; k < 200 && !(HTRANS != 2'b00 && !HWRITE); k++) @(negedge HCLK);
    chk("reached_read", {HTRANS[1], HWRITE}, 2'b10);
    HRESET = 1'b1;
    res_q.delete(); addr_q.delete(); wd_q.delete();
    @(negedge HCLK);
    chk_reset("reset_midrun");
    HRESET = 1'b0;
    repeat (20) @(negedge HCLK);
    run(32'h0000_0300, 6, 32'hCAFE_0000, 0, 0, -1, -1);

    for (int t = 0; t < 25; t++) begin
      int          n, w, kc, kr;
      bit          rw;
      logic [31:0] b;
      n  = int'($urandom_range(0, 40));
      b  = $urandom;
      if ($urandom_range(0, 1) == 1) b = (b & 32'hFFFF_FC00) - 32'($urandom_range(0, 60));
      w  = int'($urandom_range(0, 2));
      rw = ($urandom_range(0, 2) == 0);
      kc = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      kr = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run(b, n, $urandom, w, rw, kc, kr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
